pinky_regfile_sb: RTL and testbench
===================================

Name: pinky_regfile_sb

Overview:
- Parametrised register file with a per-register busy scoreboard for the PinKY pipeline.
- Replaces the flat regfile array that the pipeline stages currently poke hierarchically.
- Provides two bypassed read ports, one write-back port and a Z condition flag.
- Raises a stall so decode holds an instruction whose sources or destination have a write still in flight. This makes deeper and longer-latency execute stages safe.

Parameters:
- WIDTH, 16: data word width in bits.
- NREGS, 16: number of architectural registers; power of two, at least 4.
- AW, $clog2(NREGS): register index width (derived).
- PC_IDX, NREGS-1: index aliased to the program counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rd_a_addr  in  AW  read port A index (Rd operand).
- rd_a_use  in  1  port A is a real source for the issuing instruction.
- rd_a_data  out  WIDTH  port A data.
- rd_b_addr  in  AW  read port B index (Op2 register).
- rd_b_use  in  1  port B is a real source.
- rd_b_data  out  WIDTH  port B data.
- iss_valid  in  1  decode presents an instruction this cycle.
- iss_wr  in  1  that instruction writes a register.
- iss_dest  in  AW  its destination index.
- stall  out  1  decode must hold; the instruction is not issued.
- wb_en  in  1  write-back valid.
- wb_addr  in  AW  write-back index.
- wb_data  in  WIDTH  write-back value.
- wb_setcc  in  1  write-back updates Z (CC == S).
- pc_in  in  WIDTH  current PC value, returned on PC_IDX reads.
- pc_wr  out  1  one-cycle strobe: write-back targeted PC_IDX.
- pc_wr_data  out  WIDTH  value written to PC, valid with pc_wr.
- z  out  1  zero flag.
- busy_vec  out  NREGS  scoreboard state, for debug and bench.
- sb_err  out  1  sticky: write-back hit a register that was not busy.

Behaviour:
- Reset low, asynchronous:
  - All registers 0.
  - busy_vec 0, z 0, pc_wr 0, pc_wr_data 0, sb_err 0.
  - stall reflects inputs combinationally but is forced 0 while reset is low.
- Reads are combinational, priority highest first:
  - Index == PC_IDX returns pc_in.
  - Else if wb_en and wb_addr == index, returns wb_data (same-cycle bypass).
  - Else returns the register contents.
- Write-back takes effect at the rising edge when wb_en is high:
  - Register wb_addr <= wb_data, except PC_IDX, whose storage is never written.
  - busy[wb_addr] cleared.
  - If wb_addr == PC_IDX: pc_wr=1 and pc_wr_data=wb_data on the following cycle, for exactly one cycle.
- Z: when wb_en and wb_setcc, z <= (wb_data == 0) at the edge. Otherwise z holds.
- Hazard term for a register r: eff_busy(r) = busy[r] and not (wb_en and wb_addr == r). A write-back in the same cycle resolves the hazard.
- stall = iss_valid and (any of):
  - rd_a_use and eff_busy(rd_a_addr)
  - rd_b_use and eff_busy(rd_b_addr)
  - iss_wr and eff_busy(iss_dest) — WAW; at most one write in flight per register.
- Reads of PC_IDX never stall; busy[PC_IDX] is still tracked so the WAW rule applies to it.
- Issue: iss_valid and not stall and iss_wr sets busy[iss_dest] at the edge.
- Simultaneous set and clear of the same index in one edge: set wins, and the new writer owns the register.
- A wb_en to a non-busy index still writes the data and sets sb_err. sb_err clears only on reset.
- Latency:
  - Read: 0 cycles.
  - Scoreboard update: 1 edge.
  - Z and register contents: visible the cycle after write-back, or the same cycle via the bypass.
- Reset asserted mid-operation clears all in-flight state. Write-backs that arrive after reset releases set sb_err; this is intended.

Decomposition:
- Shared package pinky_pkg holds:
  - WORD width, opcode constants, CC encodings (AL/S/EQ/NE).
  - PC_IDX default.
  - Macro/function decoding rd_a_use, rd_b_use and iss_wr from the opcode, used by decode.
- Sub-module pinky_scoreboard, parametrised on NREGS, holds:
  - The busy vector, set/clear logic and eff_busy.
  - stall generation and sb_err.
- pinky_regfile_sb instantiates pinky_scoreboard and adds the storage, read muxes, Z flag and PC strobe.

Test Plan:
- Reset then read all ports:
  - rd_a_addr=3 returns 0.
  - rd_b_addr=15 with pc_in=0x0042 returns 0x0042.
  - busy_vec=0, z=0, stall=0.
- Issue with iss_wr=1, iss_dest=4, no stall:
  - busy_vec[4]=1 next cycle.
  - An issue reading rd_a_addr=4 with rd_a_use=1 gives stall=1 until the write-back.
  - In the write-back cycle (wb_addr=4, wb_data=0x1234): stall=0 and rd_a_data=0x1234.
- WAW: busy[5]=1, issue with iss_dest=5 → stall=1. Same with rd_a_use=0 and rd_b_use=0 → still stall=1 (WAW alone). An issue with iss_wr=0 and no uses → stall=0.
- Same-edge wb to 6 and issue to 6:
  - busy[6]=1 afterwards.
  - Register 6 holds the wb data.
  - sb_err stays 0.
- Z flag:
  - wb_setcc=1, wb_data=0 → z=1.
  - wb_setcc=0, wb_data=0 → z unchanged.
  - wb_setcc=1, wb_data=0x0001 → z=0.
- Edge cases:
  - wb to 15, data 0x0010 → pc_wr high for exactly 1 cycle with pc_wr_data=0x0010; PC_IDX reads still return pc_in.
  - wb to non-busy 7 → sb_err=1 and sticky.
  - Reset pulse mid-stall → busy_vec=0 and stall=0 immediately.

Source files
------------

// File: rtl/pinky_pkg.sv
// Shared PinKY definitions: word width, opcodes, condition codes and the
// source/destination usage decode that drives the scoreboard inputs.
package pinky_pkg;

  localparam int WORD        = 16;
  localparam int PC_IDX_DFLT = 15;

  typedef enum logic [3:0] {
    OP_MOV = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_CMP = 4'h3,
    OP_LDR = 4'h4,
    OP_STR = 4'h5,
    OP_B   = 4'h6,
    OP_NOP = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    CC_AL = 2'b00,
    CC_S  = 2'b01,
    CC_EQ = 2'b10,
    CC_NE = 2'b11
  } cc_e;

  typedef struct packed {
    logic rd_a_use;
    logic rd_b_use;
    logic iss_wr;
  } op_use_t;

  // Rd is read as an operand by ALU ops and STR; CMP only produces flags.
  function automatic op_use_t decode_use(input opcode_e op);
    op_use_t u;
    u = '0;
    case (op)
      OP_MOV:               u = '{rd_a_use: 1'b0, rd_b_use: 1'b1, iss_wr: 1'b1};
      OP_ADD, OP_SUB:       u = '{rd_a_use: 1'b1, rd_b_use: 1'b1, iss_wr: 1'b1};
      OP_CMP:               u = '{rd_a_use: 1'b1, rd_b_use: 1'b1, iss_wr: 1'b0};
      OP_LDR:               u = '{rd_a_use: 1'b0, rd_b_use: 1'b1, iss_wr: 1'b1};
      OP_STR:               u = '{rd_a_use: 1'b1, rd_b_use: 1'b1, iss_wr: 1'b0};
      OP_B:                 u = '{rd_a_use: 1'b0, rd_b_use: 1'b1, iss_wr: 1'b0};
      default:              u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/pinky_scoreboard.sv
// Per-register busy tracking, issue stall generation and the sticky
// write-back-to-idle-register error flag.
module pinky_scoreboard
  import pinky_pkg::*;
#(
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS),
  parameter int PC_IDX = NREGS - 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [AW-1:0]    i_rd_a_addr,
  input  logic             i_rd_a_use,
  input  logic [AW-1:0]    i_rd_b_addr,
  input  logic             i_rd_b_use,
  input  logic             i_iss_valid,
  input  logic             i_iss_wr,
  input  logic [AW-1:0]    i_iss_dest,
  input  logic             i_wb_en,
  input  logic [AW-1:0]    i_wb_addr,
  output logic             o_stall,
  output logic [NREGS-1:0] o_busy_vec,
  output logic             o_sb_err
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             r_sb_err;
  logic             w_haz_a;
  logic             w_haz_b;
  logic             w_haz_d;
  logic             w_issue;

  // A write-back landing this cycle already resolves the hazard.
  function automatic logic eff_busy(input logic [AW-1:0] r);
    return r_busy[r] && !(i_wb_en && (i_wb_addr == r));
  endfunction

  always_comb begin
    w_haz_a = i_rd_a_use && (i_rd_a_addr != PC_A) && eff_busy(i_rd_a_addr);
    w_haz_b = i_rd_b_use && (i_rd_b_addr != PC_A) && eff_busy(i_rd_b_addr);
    w_haz_d = i_iss_wr && eff_busy(i_iss_dest);
    o_stall = i_rst_n && i_iss_valid && (w_haz_a || w_haz_b || w_haz_d);
    w_issue = i_iss_valid && !o_stall && i_iss_wr;
  end

  // Clear first, then set, so a new writer issued on the same edge owns the register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wb_en) w_busy_nxt[i_wb_addr] = 1'b0;
    if (w_issue) w_busy_nxt[i_iss_dest] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (i_wb_en && !r_busy[i_wb_addr]) r_sb_err <= 1'b1;
    end
  end

  assign o_busy_vec = r_busy;
  assign o_sb_err   = r_sb_err;

endmodule

// File: rtl/pinky_regfile_sb.sv
// PinKY register file: storage, bypassed read ports, Z flag, PC write strobe,
// with the issue scoreboard instantiated alongside.
module pinky_regfile_sb
  import pinky_pkg::*;
#(
  parameter int WIDTH  = WORD,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS),
  parameter int PC_IDX = NREGS - 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [AW-1:0]    i_rd_a_addr,
  input  logic             i_rd_a_use,
  output logic [WIDTH-1:0] o_rd_a_data,
  input  logic [AW-1:0]    i_rd_b_addr,
  input  logic             i_rd_b_use,
  output logic [WIDTH-1:0] o_rd_b_data,
  input  logic             i_iss_valid,
  input  logic             i_iss_wr,
  input  logic [AW-1:0]    i_iss_dest,
  output logic             o_stall,
  input  logic             i_wb_en,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic [WIDTH-1:0] i_wb_data,
  input  logic             i_wb_setcc,
  input  logic [WIDTH-1:0] i_pc_in,
  output logic             o_pc_wr,
  output logic [WIDTH-1:0] o_pc_wr_data,
  output logic             o_z,
  output logic [NREGS-1:0] o_busy_vec,
  output logic             o_sb_err
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_z;
  logic             r_pc_wr;
  logic [WIDTH-1:0] r_pc_wr_data;
  logic             w_wb_pc;

  function automatic logic [WIDTH-1:0] rd_mux(input logic [AW-1:0] a);
    if (a == PC_A)                      return i_pc_in;
    else if (i_wb_en && i_wb_addr == a) return i_wb_data;
    else                                return r_regs[a];
  endfunction

  assign o_rd_a_data = rd_mux(i_rd_a_addr);
  assign o_rd_b_data = rd_mux(i_rd_b_addr);
  assign w_wb_pc     = i_wb_en && (i_wb_addr == PC_A);

  // The PC slot has no storage of its own; writes to it only raise the strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_z          <= 1'b0;
      r_pc_wr      <= 1'b0;
      r_pc_wr_data <= '0;
    end else begin
      if (i_wb_en && !w_wb_pc) r_regs[i_wb_addr] <= i_wb_data;
      if (i_wb_en && i_wb_setcc) r_z <= (i_wb_data == '0);
      r_pc_wr <= w_wb_pc;
      if (w_wb_pc) r_pc_wr_data <= i_wb_data;
    end
  end

  assign o_z          = r_z;
  assign o_pc_wr      = r_pc_wr;
  assign o_pc_wr_data = r_pc_wr_data;

  pinky_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .PC_IDX (PC_IDX)
  ) u_sb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rd_a_addr (i_rd_a_addr),
    .i_rd_a_use  (i_rd_a_use),
    .i_rd_b_addr (i_rd_b_addr),
    .i_rd_b_use  (i_rd_b_use),
    .i_iss_valid (i_iss_valid),
    .i_iss_wr    (i_iss_wr),
    .i_iss_dest  (i_iss_dest),
    .i_wb_en     (i_wb_en),
    .i_wb_addr   (i_wb_addr),
    .o_stall     (o_stall),
    .o_busy_vec  (o_busy_vec),
    .o_sb_err    (o_sb_err)
  );

endmodule

// File: tb/tb_pinky_regfile_sb.sv
// Directed bench for pinky_regfile_sb: reset, RAW/WAW stalls, same-edge
// set/clear, Z flag, PC strobe, sb_err and asynchronous reset mid-stall.
module tb_pinky_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rd_a_addr, rd_b_addr, iss_dest, wb_addr;
  logic        rd_a_use, rd_b_use, iss_valid, iss_wr, wb_en, wb_setcc;
  logic [15:0] rd_a_data, rd_b_data, wb_data, pc_in, pc_wr_data;
  logic        stall, pc_wr, z, sb_err;
  logic [15:0] busy_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pinky_regfile_sb dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rd_a_addr  (rd_a_addr),
    .i_rd_a_use   (rd_a_use),
    .o_rd_a_data  (rd_a_data),
    .i_rd_b_addr  (rd_b_addr),
    .i_rd_b_use   (rd_b_use),
    .o_rd_b_data  (rd_b_data),
    .i_iss_valid  (iss_valid),
    .i_iss_wr     (iss_wr),
    .i_iss_dest   (iss_dest),
    .o_stall      (stall),
    .i_wb_en      (wb_en),
    .i_wb_addr    (wb_addr),
    .i_wb_data    (wb_data),
    .i_wb_setcc   (wb_setcc),
    .i_pc_in      (pc_in),
    .o_pc_wr      (pc_wr),
    .o_pc_wr_data (pc_wr_data),
    .o_z          (z),
    .o_busy_vec   (busy_vec),
    .o_sb_err     (sb_err)
  );

  task automatic idle();
    rd_a_addr = 4'd0; rd_a_use = 1'b0;
    rd_b_addr = 4'd0; rd_b_use = 1'b0;
    iss_valid = 1'b0; iss_wr = 1'b0; iss_dest = 4'd0;
    wb_en = 1'b0; wb_addr = 4'd0; wb_data = 16'h0; wb_setcc = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [3:0] d);
    idle();
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    pc_in = 16'h0042;
    rst_n = 1'b0;
    iss_valid = 1'b1; iss_wr = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_forced: got %b want 0", stall); end
    idle();
    tick(); tick();
    rst_n = 1'b1;
    rd_a_addr = 4'd3; rd_b_addr = 4'd15;
    #1;
    checks++;
    if (rd_a_data !== 16'h0) begin errors++; $display("FAIL reset_rd_a: got %h want 0000", rd_a_data); end
    checks++;
    if (rd_b_data !== 16'h0042) begin errors++; $display("FAIL reset_rd_b_pc: got %h want 0042", rd_b_data); end
    checks++;
    if (busy_vec !== 16'h0 || z !== 1'b0 || stall !== 1'b0 || sb_err !== 1'b0 || pc_wr !== 1'b0 || pc_wr_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%h z=%b stall=%b sb_err=%b pc_wr=%b pc_wr_data=%h want all 0",
               busy_vec, z, stall, sb_err, pc_wr, pc_wr_data);
    end
  endtask

  task automatic test_raw();
    idle();
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 4'd4;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL raw_issue_nostall: got %b want 0", stall); end
    tick();
    idle();
    checks++;
    if (busy_vec !== 16'h0010) begin errors++; $display("FAIL raw_busy_set: got %h want 0010", busy_vec); end
    iss_valid = 1'b1; rd_a_use = 1'b1; rd_a_addr = 4'd4;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall0: got %b want 1", stall); end
    tick();
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall1: got %b want 1", stall); end
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h1234;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL raw_wb_unstall: got %b want 0", stall); end
    checks++;
    if (rd_a_data !== 16'h1234) begin errors++; $display("FAIL raw_bypass: got %h want 1234", rd_a_data); end
    tick();
    idle();
    rd_b_addr = 4'd4;
    #1;
    checks++;
    if (busy_vec !== 16'h0 || rd_b_data !== 16'h1234 || sb_err !== 1'b0) begin
      errors++;
      $display("FAIL raw_after_wb: busy=%h rd_b=%h sb_err=%b want 0000 1234 0", busy_vec, rd_b_data, sb_err);
    end
  endtask

  task automatic test_waw();
    issue_wr(4'd5);
    checks++;
    if (busy_vec !== 16'h0020) begin errors++; $display("FAIL waw_busy: got %h want 0020", busy_vec); end
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 4'd5; rd_a_use = 1'b1; rd_a_addr = 4'd0;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall_uses: got %b want 1", stall); end
    rd_a_use = 1'b0; rd_b_use = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall_alone: got %b want 1", stall); end
    iss_wr = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL waw_nowr: got %b want 0", stall); end
    idle();
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'h5555;
    tick();
    idle();
    checks++;
    if (busy_vec !== 16'h0) begin errors++; $display("FAIL waw_clear: got %h want 0000", busy_vec); end
  endtask

  task automatic test_same_edge();
    issue_wr(4'd6);
    wb_en = 1'b1; wb_addr = 4'd6; wb_data = 16'hABCD;
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 4'd6;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL same_nostall: got %b want 0", stall); end
    tick();
    idle();
    rd_b_addr = 4'd6;
    #1;
    checks++;
    if (busy_vec !== 16'h0040) begin errors++; $display("FAIL same_busy: got %h want 0040", busy_vec); end
    checks++;
    if (rd_b_data !== 16'hABCD) begin errors++; $display("FAIL same_data: got %h want abcd", rd_b_data); end
    checks++;
    if (sb_err !== 1'b0) begin errors++; $display("FAIL same_sb_err: got %b want 0", sb_err); end
    idle();
    wb_en = 1'b1; wb_addr = 4'd6; wb_data = 16'h0BCD;
    tick();
    idle();
  endtask

  task automatic test_z();
    logic [15:0] dv [4];
    logic        sv [4];
    logic        ez [4];
    dv = '{16'h0000, 16'h0005, 16'h0001, 16'h0000};
    sv = '{1'b1,     1'b0,     1'b1,     1'b0};
    ez = '{1'b1,     1'b1,     1'b0,     1'b0};
    for (int i = 0; i < 4; i++) begin
      issue_wr(4'(i + 1));
      wb_en = 1'b1; wb_addr = 4'(i + 1); wb_data = dv[i]; wb_setcc = sv[i];
      tick();
      idle();
      checks++;
      if (z !== ez[i]) begin errors++; $display("FAIL z_step%0d: got %b want %b", i, z, ez[i]); end
    end
    checks++;
    if (sb_err !== 1'b0) begin errors++; $display("FAIL z_sb_err: got %b want 0", sb_err); end
  endtask

  task automatic test_pc();
    issue_wr(4'd15);
    checks++;
    if (busy_vec !== 16'h8000) begin errors++; $display("FAIL pc_busy: got %h want 8000", busy_vec); end
    pc_in = 16'h0077;
    iss_valid = 1'b1; rd_a_use = 1'b1; rd_a_addr = 4'd15;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL pc_read_nostall: got %b want 0", stall); end
    wb_en = 1'b1; wb_addr = 4'd15; wb_data = 16'h0010;
    #1;
    checks++;
    if (rd_a_data !== 16'h0077) begin errors++; $display("FAIL pc_read_wb: got %h want 0077", rd_a_data); end
    tick();
    idle();
    rd_b_addr = 4'd15;
    #1;
    checks++;
    if (pc_wr !== 1'b1 || pc_wr_data !== 16'h0010) begin
      errors++; $display("FAIL pc_strobe: pc_wr=%b data=%h want 1 0010", pc_wr, pc_wr_data);
    end
    checks++;
    if (rd_b_data !== 16'h0077) begin errors++; $display("FAIL pc_read_after: got %h want 0077", rd_b_data); end
    tick();
    checks++;
    if (pc_wr !== 1'b0) begin errors++; $display("FAIL pc_strobe_len: got %b want 0", pc_wr); end
    checks++;
    if (busy_vec !== 16'h0 || sb_err !== 1'b0) begin
      errors++; $display("FAIL pc_after: busy=%h sb_err=%b want 0000 0", busy_vec, sb_err);
    end
  endtask

  task automatic test_sb_err();
    idle();
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 16'h7777;
    tick();
    idle();
    rd_a_addr = 4'd7;
    #1;
    checks++;
    if (sb_err !== 1'b1) begin errors++; $display("FAIL sb_err_set: got %b want 1", sb_err); end
    checks++;
    if (rd_a_data !== 16'h7777) begin errors++; $display("FAIL sb_err_data: got %h want 7777", rd_a_data); end
    tick(); tick();
    checks++;
    if (sb_err !== 1'b1) begin errors++; $display("FAIL sb_err_sticky: got %b want 1", sb_err); end
  endtask

  task automatic test_reset_mid();
    issue_wr(4'd8);
    iss_valid = 1'b1; rd_b_use = 1'b1; rd_b_addr = 4'd8;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL mid_stall: got %b want 1", stall); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_vec !== 16'h0 || stall !== 1'b0 || sb_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset: busy=%h stall=%b sb_err=%b want 0000 0 0", busy_vec, stall, sb_err);
    end
    rd_a_addr = 4'd4;
    #1;
    checks++;
    if (rd_a_data !== 16'h0) begin errors++; $display("FAIL mid_reset_regs: got %h want 0000", rd_a_data); end
    tick();
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_same_edge();
    test_z();
    test_pc();
    test_sb_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
